// File: rtl/mux_bus_arbiter_pkg.sv
// Shared types and round-robin search helper
// for the shared-bus multiplexer arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        YIELD = 2'd2
    } arb_state_t;

    localparam int MAX_SEL = 5;
    localparam int MAX_N   = 1 << MAX_SEL;

    typedef struct packed {
        logic               found;
        logic [MAX_SEL-1:0] index;
    } rr_pick_t;

    // Search order ptr, ptr+1, ... mod n; the
    // lowest offset from ptr wins. Walking the
    // offsets downward lets the last hit stand.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_N-1:0]   request,
        input logic [MAX_SEL-1:0] ptr,
        input int                 n
    );
        rr_pick_t r;
        int       k;
        r = '0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (i < n) begin
                k = (int'(ptr) + i) % n;
                if (request[k]) begin
                    r.found = 1'b1;
                    r.index = MAX_SEL'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_bus_arbiter_if.sv
// Request/grant/select bundle between the
// requesters (master) and the arbiter (slave).
interface mux_bus_arbiter_if #(
    parameter int SEL_WIDTH = 2,
    parameter int MAX_BURST = 8
);
    localparam int N  = 1 << SEL_WIDTH;
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [N-1:0]         request;
    logic [N-1:0]         grant;
    logic [SEL_WIDTH-1:0] control_signals;
    logic                 bus_valid;
    logic [CW-1:0]        burst_count;

    modport master (
        output request,
        input  grant,
        input  control_signals,
        input  bus_valid,
        input  burst_count
    );

    modport slave (
        input  request,
        output grant,
        output control_signals,
        output bus_valid,
        output burst_count
    );

endinterface

// File: rtl/mux_bus_arbiter_rr_priority_encoder.sv
// Combinational round-robin priority encoder:
// first set request at or after ptr, wrapping.
module rr_priority_encoder
    import mux_arb_pkg::*;
#(
    parameter int SEL_WIDTH = 2
) (
    input  logic [(1<<SEL_WIDTH)-1:0] request,
    input  logic [SEL_WIDTH-1:0]      ptr,
    output logic                      valid,
    output logic [SEL_WIDTH-1:0]      index
);
    localparam int N = 1 << SEL_WIDTH;

    rr_pick_t pick;

    // Widen to the helper's fixed size, search, narrow back.
    always_comb begin
        pick  = rr_pick(MAX_N'(request), MAX_SEL'(ptr), N);
        valid = pick.found;
        index = SEL_WIDTH'(pick.index);
    end

endmodule

// File: rtl/mux_bus_arbiter.sv
// Round-robin owner of a shared mux with burst
// limit and a one-cycle turnaround between owners.
module mux_bus_arbiter
    import mux_arb_pkg::*;
#(
    parameter int SEL_WIDTH = 2,
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    mux_bus_arbiter_if.slave bus
);
    localparam int N  = 1 << SEL_WIDTH;
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t           state_q, state_d;
    logic [N-1:0]         grant_q, grant_d;
    logic [SEL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic                 valid_q, valid_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;

    logic                 win_valid;
    logic [SEL_WIDTH-1:0] win_idx;
    logic [N-1:0]         owner_mask;
    logic                 owner_req;
    logic                 others_req;
    logic                 cnt_max;

    rr_priority_encoder #(
        .SEL_WIDTH (SEL_WIDTH)
    ) u_rr_enc (
        .request (bus.request),
        .ptr     (ptr_q),
        .valid   (win_valid),
        .index   (win_idx)
    );

    // Owner's own request and whether anyone else waits.
    always_comb begin
        owner_mask = N'(1) << ctrl_q;
        owner_req  = |(bus.request & owner_mask);
        others_req = |(bus.request & ~owner_mask);
        cnt_max    = (cnt_q == CW'(MAX_BURST));
    end

    // Next state: arbitrate from idle/turnaround, hold or release when owned.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE, YIELD: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
                if (win_valid) begin
                    state_d = OWNED;
                    grant_d = N'(1) << win_idx;
                    ctrl_d  = win_idx;
                    valid_d = 1'b1;
                    cnt_d   = CW'(1);
                end
            end
            OWNED: begin
                if (!owner_req || (cnt_max && others_req)) begin
                    state_d = YIELD;
                    grant_d = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    ptr_d   = ctrl_q + SEL_WIDTH'(1);
                end else if (!cnt_max) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs; reset clears without a turnaround.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.grant           = grant_q;
    assign bus.control_signals = ctrl_q;
    assign bus.bus_valid       = valid_q;
    assign bus.burst_count     = cnt_q;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Bench for mux_bus_arbiter: two instances (MAX_BURST 8 and 2)
// against an owner/pointer model, plus directed literal checks.
module tb_mux_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;

    int n_tests = 0;
    int n_fail  = 0;

    mux_bus_arbiter_if #(.SEL_WIDTH(2), .MAX_BURST(8)) bus8 ();
    mux_bus_arbiter_if #(.SEL_WIDTH(2), .MAX_BURST(2)) bus2 ();

    assign bus8.request = req;
    assign bus2.request = req;

    mux_bus_arbiter #(.SEL_WIDTH(2), .MAX_BURST(8)) u8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8)
    );

    mux_bus_arbiter #(.SEL_WIDTH(2), .MAX_BURST(2)) u2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    always #5 clk = ~clk;

    // Model: who owns the bus (-1 = nobody), how long, last owner, pointer.
    int m_own[2];
    int m_cnt[2];
    int m_last[2];
    int m_ptr[2];
    int m_mb[2] = '{8, 2};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_own[d]  = -1;
            m_cnt[d]  = 0;
            m_last[d] = 0;
            m_ptr[d]  = 0;
        end
    endtask

    task automatic m_step(input int d, input logic [3:0] r);
        int  o;
        bit  others;
        o = m_own[d];
        if (o >= 0) begin
            others = 1'b0;
            for (int j = 0; j < 4; j++)
                if (j != o && r[j]) others = 1'b1;
            if (!r[o] || (m_cnt[d] == m_mb[d] && others)) begin
                m_ptr[d] = (o + 1) % 4;
                m_own[d] = -1;
                m_cnt[d] = 0;
            end else if (m_cnt[d] < m_mb[d]) begin
                m_cnt[d] = m_cnt[d] + 1;
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (r[(m_ptr[d] + i) % 4]) begin
                    m_own[d]  = (m_ptr[d] + i) % 4;
                    m_last[d] = m_own[d];
                    m_cnt[d]  = 1;
                end
            end
        end
    endtask

    // Model advances on each sampled edge; async reset clears it at once.
    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_reset();
            end else begin
                m_step(0, req);
                m_step(1, req);
            end
        end
    end

    function automatic logic [3:0] m_grant(input int d);
        return (m_own[d] >= 0) ? 4'(1 << m_own[d]) : 4'b0000;
    endfunction

    // Every cycle, mid-period, both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("u8.grant", 32'(bus8.grant), 32'(m_grant(0)));
            chk("u8.ctrl", 32'(bus8.control_signals), 32'(m_last[0]));
            chk("u8.valid", 32'(bus8.bus_valid), 32'(m_own[0] >= 0));
            chk("u8.cnt", 32'(bus8.burst_count), 32'(m_cnt[0]));
            chk("u2.grant", 32'(bus2.grant), 32'(m_grant(1)));
            chk("u2.ctrl", 32'(bus2.control_signals), 32'(m_last[1]));
            chk("u2.valid", 32'(bus2.bus_valid), 32'(m_own[1] >= 0));
            chk("u2.cnt", 32'(bus2.burst_count), 32'(m_cnt[1]));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Advance to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] rr_exp [13] = '{
        4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
        4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
        4'b0001
    };

    initial begin
        // Reset held with every request up.
        req = 4'b1111;
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            #4;
            chk("rst.grant", 32'(bus8.grant), 32'h0);
            chk("rst.ctrl", 32'(bus8.control_signals), 32'h0);
            chk("rst.valid", 32'(bus8.bus_valid), 32'h0);
        end
        step();
        reset_n = 1'b1;

        // Round robin on the MAX_BURST=2 instance.
        for (int k = 0; k < 13; k++) begin
            step();
            #4;
            if (k == 0) begin
                chk("rel.grant", 32'(bus8.grant), 32'h1);
                chk("rel.cnt", 32'(bus8.burst_count), 32'h1);
            end
            chk($sformatf("rr[%0d]", k), 32'(bus2.grant), 32'(rr_exp[k]));
        end

        step();
        reset_n = 1'b0;
        req = 4'b0000;
        step();
        reset_n = 1'b1;

        // Single requester for three cycles.
        req = 4'b0100;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 3) req = 4'b0000;
            #4;
            chk("single.grant", 32'(bus8.grant), 32'h4);
            chk("single.ctrl", 32'(bus8.control_signals), 32'h2);
            chk("single.cnt", 32'(bus8.burst_count), 32'(k));
        end
        step();
        #4;
        chk("single.yield", 32'(bus8.grant), 32'h0);
        chk("single.hold_ctrl", 32'(bus8.control_signals), 32'h2);
        step();

        // Saturation without contention.
        req = 4'b0010;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 12) req = 4'b0000;
            #4;
            chk("sat.grant", 32'(bus8.grant), 32'h2);
            chk("sat.cnt", 32'(bus8.burst_count), 32'((k < 8) ? k : 8));
        end
        step();
        step();

        // Priority after release (pointer now at 2).
        req = 4'b0001;
        step();
        req = 4'b1010;
        #4;
        chk("prio.own0", 32'(bus8.grant), 32'h1);
        step();
        #4;
        chk("prio.yield0", 32'(bus8.grant), 32'h0);
        step();
        req = 4'b1000;
        #4;
        chk("prio.own1", 32'(bus8.grant), 32'h2);
        step();
        #4;
        chk("prio.yield1", 32'(bus8.grant), 32'h0);
        step();
        req = 4'b0000;
        #4;
        chk("prio.own3", 32'(bus8.grant), 32'h8);
        step();
        step();

        // Async reset mid-burst with pointer moved to 3.
        req = 4'b0100;
        step();
        req = 4'b0000;
        step();
        step();
        req = 4'b0100;
        step();
        step();
        chk("areset.before", 32'(bus8.grant), 32'h4);
        reset_n = 1'b0;
        #1;
        chk("areset.grant", 32'(bus8.grant), 32'h0);
        chk("areset.valid", 32'(bus8.bus_valid), 32'h0);
        chk("areset.cnt", 32'(bus8.burst_count), 32'h0);
        step();
        req = 4'b1111;
        reset_n = 1'b1;
        step();
        #4;
        chk("areset.ptr0", 32'(bus8.grant), 32'h1);
        chk("areset.ctrl", 32'(bus8.control_signals), 32'h0);

        // Randomized traffic with occasional async resets.
        for (int k = 0; k < 600; k++) begin
            step();
            if (!reset_n)
                reset_n = 1'b1;
            else if ($urandom_range(0, 149) == 0)
                reset_n = 1'b0;
            if ($urandom_range(0, 9) < 3)
                req = 4'($urandom_range(0, 15));
        end
        req = 4'b0000;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
